// File: rtl/pacman_mover_pkg.sv
// rtl/pacman_mover_pkg.sv - shared game types: directions, mover FSM states, target step helper
package pacman_mover_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

    // One-pixel step from (x, y) in direction dir, returned as {tx, ty}.
    // The playfield wraps horizontally at x_max and clamps vertically at 0/255.
    function automatic logic [15:0] step_target(input logic [7:0] x,
                                                input logic [7:0] y,
                                                input dir_t       dir,
                                                input logic [7:0] x_max);
        logic [7:0] tx;
        logic [7:0] ty;
        tx = x;
        ty = y;
        case (dir)
            DIR_UP:    ty = (y == 8'd0)   ? y     : y - 8'd1;
            DIR_DOWN:  ty = (y == 8'd255) ? y     : y + 8'd1;
            DIR_LEFT:  tx = (x == 8'd0)   ? x_max : x - 8'd1;
            DIR_RIGHT: tx = (x == x_max)  ? 8'd0  : x + 8'd1;
            default:   ;
        endcase
        return {tx, ty};
    endfunction

endpackage

// File: rtl/step_ticker.sv
// rtl/step_ticker.sv - free-running movement step divider
//
// Ports:
//   clock  in  system clock, rising edge
//   resetn in  synchronous active-low reset (counter to 0)
//   tick   out one-cycle pulse while the counter sits at TICK_DIV-1 (the wrap cycle)
module step_ticker #(
    parameter logic [19:0] TICK_DIV = 20'd833333
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    logic [19:0] count;

    assign tick = (count == TICK_DIV - 20'd1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= 20'd0;
        end else if (tick) begin
            count <= 20'd0;
        end else begin
            count <= count + 20'd1;
        end
    end

endmodule

// File: rtl/pacman_mover.sv
// rtl/pacman_mover.sv - Pacman position stepper with collision-checker handshake
//
// Ports:
//   clock, resetn                          clock and synchronous active-low reset
//   key_up/key_down/key_left/key_right     level direction requests, up > down > left > right
//   move_next, able_to_move                collision checker response pulse and verdict
//   target_x, target_y, target_valid       coordinate to test, with one-cycle valid pulse
//   pacman_x, pacman_y                     committed position
//   facing                                 active direction (0 up, 1 down, 2 left, 3 right)
//   moved                                  one-cycle pulse per committed position change
//
// Each state's outputs are registered on the edge that enters it, so target_valid
// is high during REQUEST (one cycle after tick) and moved/the new position appear
// during UPDATE (one cycle after the accepting move_next).
module pacman_mover #(
    parameter logic [7:0]  X_INIT   = 8'd80,
    parameter logic [7:0]  Y_INIT   = 8'd60,
    parameter logic [7:0]  X_MAX    = 8'd159,
    parameter logic [19:0] TICK_DIV = 20'd833333,
    parameter logic [4:0]  TIMEOUT  = 5'd16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       move_next,
    input  logic       able_to_move,
    output logic [7:0] target_x,
    output logic [7:0] target_y,
    output logic       target_valid,
    output logic [7:0] pacman_x,
    output logic [7:0] pacman_y,
    output logic [1:0] facing,
    output logic       moved
);

    import pacman_mover_pkg::*;

    state_t      state;
    state_t      state_next;
    dir_t        pending_dir;
    dir_t        facing_q;
    logic [4:0]  wait_count;
    logic        tick;
    logic [7:0]  step_x;
    logic [7:0]  step_y;
    logic        start_req;
    logic        accept;
    logic        timed_out;

    step_ticker #(
        .TICK_DIV (TICK_DIV)
    ) u_ticker (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    // pending_dir becomes the active direction as the request is launched,
    // so the step is computed from it directly.
    assign {step_x, step_y} = step_target(pacman_x, pacman_y, pending_dir, X_MAX);

    assign facing    = facing_q;
    assign start_req = (state == ST_IDLE) && tick;
    assign accept    = (state == ST_WAIT_RESP) && move_next && able_to_move;
    assign timed_out = (wait_count == TIMEOUT - 5'd1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                state_next = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (move_next) begin
                    state_next = able_to_move ? ST_UPDATE : ST_IDLE;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pending_dir  <= DIR_LEFT;
            facing_q     <= DIR_LEFT;
            target_x     <= X_INIT;
            target_y     <= Y_INIT;
            target_valid <= 1'b0;
            pacman_x     <= X_INIT;
            pacman_y     <= Y_INIT;
            moved        <= 1'b0;
            wait_count   <= 5'd0;
        end else begin
            target_valid <= 1'b0;
            moved        <= 1'b0;

            // No key held: keep the last requested direction.
            if (key_up) begin
                pending_dir <= DIR_UP;
            end else if (key_down) begin
                pending_dir <= DIR_DOWN;
            end else if (key_left) begin
                pending_dir <= DIR_LEFT;
            end else if (key_right) begin
                pending_dir <= DIR_RIGHT;
            end

            if (start_req) begin
                facing_q     <= pending_dir;
                target_x     <= step_x;
                target_y     <= step_y;
                target_valid <= 1'b1;
            end

            // Counts cycles spent in WAIT_RESP; zero on the first one.
            if (state == ST_WAIT_RESP) begin
                wait_count <= wait_count + 5'd1;
            end else begin
                wait_count <= 5'd0;
            end

            // A clamped step targets the current position: commit it silently.
            if (accept) begin
                pacman_x <= target_x;
                pacman_y <= target_y;
                moved    <= (target_x != pacman_x) || (target_y != pacman_y);
            end
        end
    end

endmodule
